bit_unstuff: RTL and testbench
==============================

BIT_UNSTUFF -- requirements
Module: bit_unstuff

Interface
REQ-001 Parameter: RUN_LEN, 6, number of consecutive 1s after which the transmitter inserts one stuffed 0.
REQ-002 Parameter: DROP_W, 8, width of the stuffed-bit drop counter.
REQ-003 Port: clk  input  1  sole clock, all state updates on its rising edge.
REQ-004 Port: rst_L  input  1  reset, asynchronous and active-low.
REQ-005 Port: inb  input  1  received (stuffed) serial bit.
REQ-006 Port: in_valid  input  1  inb carries a bit this cycle; cycles with in_valid=0 are ignored.
REQ-007 Port: clr  input  1  synchronous packet-boundary clear of run counter, error flag and drop counter.
REQ-008 Port: outb  output  1  destuffed data bit, registered.
REQ-009 Port: out_valid  output  1  outb carries a payload bit this cycle, registered.
REQ-010 Port: stuff_err  output  1  one-cycle pulse: a 1 arrived where a stuffed 0 was required.
REQ-011 Port: err_sticky  output  1  set by any stuff_err, held until clr or reset.
REQ-012 Port: drop_cnt  output  DROP_W  count of correctly removed stuffed 0s since last clr or reset.

Function
REQ-013 Block SHALL keep a run counter ones of width $clog2(RUN_LEN+1) counting consecutive valid 1s, range 0..RUN_LEN.
REQ-014 Latency SHALL be exactly one cycle: a bit accepted at edge N appears on outb/out_valid after edge N and holds for one cycle.
REQ-015 Valid bit with ones<RUN_LEN: next-cycle out_valid=1, outb=inb; ones increments if inb=1, else clears to 0.
REQ-016 Valid bit with ones==RUN_LEN and inb=0: stuffed bit; next-cycle out_valid=0, ones=0, drop_cnt increments.
REQ-017 Valid bit with ones==RUN_LEN and inb=1: stuff violation; next-cycle out_valid=0, stuff_err=1, err_sticky=1, ones=0, drop_cnt unchanged.
REQ-018 The violating 1 SHALL be discarded, not forwarded; counting restarts at 0 with the following valid bit.
REQ-019 in_valid=0: ones, err_sticky, drop_cnt held; next-cycle out_valid=0, stuff_err=0; outb holds its previous value.
REQ-020 Gaps in in_valid SHALL NOT break a run: six valid 1s separated by invalid cycles still make ones reach RUN_LEN.
REQ-021 drop_cnt SHALL saturate at 2^DROP_W-1, never wrap.
REQ-022 stuff_err SHALL be high for exactly one cycle per violation; back-to-back violations give separate pulses.
REQ-023 clr=1 SHALL take priority over in_valid: next cycle ones=0, err_sticky=0, drop_cnt=0, out_valid=0, stuff_err=0; the input bit that cycle is discarded.
REQ-024 A run of exactly RUN_LEN-1 ones followed by a valid 0 SHALL forward all bits and clear ones without dropping anything.
REQ-025 Block SHALL be the exact inverse of the team's bit stuffer: stuffer output fed here with in_valid=1 every cycle reproduces the original stream, with pause cycles appearing as out_valid=0.

Reset
REQ-026 rst_L=0 SHALL immediately force ones=0, outb=0, out_valid=0, stuff_err=0, err_sticky=0, drop_cnt=0, independent of clk.
REQ-027 Reset asserted mid-run SHALL discard the partial run; first valid bit after deassertion starts counting from ones=0.
REQ-028 Deassertion SHALL be accepted on any cycle; first capture at the first rising clk edge with rst_L=1.

Verification
REQ-029 Stream 1,1,1,1,1,1,0,1 all valid -> out_valid pattern 1,1,1,1,1,1,0,1 one cycle later, outb 1s, drop_cnt=1, no stuff_err.
REQ-030 Stream 1x7 all valid -> seventh bit gives stuff_err pulse and err_sticky=1, out_valid=0 that cycle, drop_cnt=0; next 0 forwarded normally.
REQ-031 Stream 1,1,1,1,1,0 -> six forwarded bits, ones=0, drop_cnt=0, no error.
REQ-032 1,1,1 then in_valid=0 for 4 cycles then 1,1,1,0 -> 0 dropped, drop_cnt=1, out_valid=0 during gap.
REQ-033 clr asserted with in_valid=1 while err_sticky=1, drop_cnt=5 -> next cycle err_sticky=0, drop_cnt=0, out_valid=0, bit lost.
REQ-034 Loopback from bit stuffer with random 1-heavy stream, rst_L pulsed mid-run -> payload matches source, drop_cnt saturates at 255 on long runs, no stuff_err.

Source files
------------

// File: rtl/bit_unstuff.sv
// Serial bit destuffer: drops the 0 inserted after every RUN_LEN consecutive 1s,
// flags a 1 in that position as a stuffing violation, and counts removed bits.
module bit_unstuff #(
    parameter int unsigned RUN_LEN = 6,
    parameter int unsigned DROP_W  = 8
) (
    input  logic              clk,
    input  logic              rst_L,
    input  logic              inb,
    input  logic              in_valid,
    input  logic              clr,
    output logic              outb,
    output logic              out_valid,
    output logic              stuff_err,
    output logic              err_sticky,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int unsigned CntW = $clog2(RUN_LEN + 1);
    localparam logic [CntW-1:0] RunMax = CntW'(RUN_LEN);

    logic [CntW-1:0]   ones_q, ones_d;
    logic              outb_d;
    logic              out_valid_d;
    logic              stuff_err_d;
    logic              err_sticky_d;
    logic [DROP_W-1:0] drop_cnt_d;

    always_comb begin
        ones_d       = ones_q;
        outb_d       = outb;
        out_valid_d  = 1'b0;
        stuff_err_d  = 1'b0;
        err_sticky_d = err_sticky;
        drop_cnt_d   = drop_cnt;

        if (clr) begin
            // Packet boundary wins over any bit presented in the same cycle.
            ones_d       = '0;
            err_sticky_d = 1'b0;
            drop_cnt_d   = '0;
        end else if (in_valid) begin
            if (ones_q == RunMax) begin
                // This slot must hold the stuffed 0; it is never forwarded.
                ones_d = '0;
                if (inb) begin
                    stuff_err_d  = 1'b1;
                    err_sticky_d = 1'b1;
                end else if (drop_cnt != {DROP_W{1'b1}}) begin
                    drop_cnt_d = drop_cnt + 1'b1;
                end
            end else begin
                out_valid_d = 1'b1;
                outb_d      = inb;
                ones_d      = inb ? ones_q + 1'b1 : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            ones_q     <= '0;
            outb       <= 1'b0;
            out_valid  <= 1'b0;
            stuff_err  <= 1'b0;
            err_sticky <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            ones_q     <= ones_d;
            outb       <= outb_d;
            out_valid  <= out_valid_d;
            stuff_err  <= stuff_err_d;
            err_sticky <= err_sticky_d;
            drop_cnt   <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_bit_unstuff.sv
// Self-checking bench for bit_unstuff: scoreboard of expected payload bits plus
// per-scenario checks of error pulses, sticky flag and drop counter.
module tb_bit_unstuff;

    logic       clk = 1'b0;
    logic       rst_L;
    logic       inb = 1'b0;
    logic       in_valid = 1'b0;
    logic       clr = 1'b0;
    logic       outb;
    logic       out_valid;
    logic       stuff_err;
    logic       err_sticky;
    logic [7:0] drop_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int err_pulses = 0;
    bit sb[$];

    bit_unstuff #(.RUN_LEN(6), .DROP_W(8)) dut (
        .clk        (clk),
        .rst_L      (rst_L),
        .inb        (inb),
        .in_valid   (in_valid),
        .clr        (clr),
        .outb       (outb),
        .out_valid  (out_valid),
        .stuff_err  (stuff_err),
        .err_sticky (err_sticky),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    // Payload monitor: every forwarded bit must match the next scoreboard entry.
    always @(negedge clk) begin
        if (rst_L === 1'b1) begin
            if (stuff_err === 1'b1) err_pulses++;
            if (out_valid === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL payload_extra: got outb=%0b out_valid=1, required no output", outb);
                end else begin
                    bit e;
                    e = sb.pop_front();
                    if (outb !== e) begin
                        n_err++;
                        $display("FAIL payload: got outb=%0b, required %0b", outb, e);
                    end
                end
            end
        end
    end

    task automatic drive(input bit v, input bit b, input bit c);
        @(negedge clk);
        in_valid = v;
        inb      = b;
        clr      = c;
    endtask

    task automatic send(input bit b, input bit payload);
        drive(1'b1, b, 1'b0);
        if (payload) sb.push_back(b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_sb_empty(input string name);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL %s_sb_empty: got %0d pending bits, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset;
        rst_L = 1'b1;
        #1 rst_L = 1'b0;
        #1;
        n_cmp++;
        if ({outb, out_valid, stuff_err, err_sticky, drop_cnt} !== 12'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b %b %b %b %h, required all 0",
                     outb, out_valid, stuff_err, err_sticky, drop_cnt);
        end
        @(negedge clk);
        #2 rst_L = 1'b1;
    endtask

    task automatic test_stuffed;
        int p0;
        drive(1'b0, 1'b0, 1'b1);
        p0 = err_pulses;
        for (int i = 0; i < 6; i++) send(1'b1, 1'b1);
        send(1'b0, 1'b0);
        send(1'b1, 1'b1);
        idle(2);
        check_sb_empty("stuffed");
        n_cmp++;
        if (drop_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL stuffed_drop: got %0d, required 1", drop_cnt);
        end
        n_cmp++;
        if (err_pulses != p0) begin
            n_err++;
            $display("FAIL stuffed_noerr: got %0d pulses, required 0", err_pulses - p0);
        end
    endtask

    task automatic test_violation;
        int p0;
        drive(1'b0, 1'b0, 1'b1);
        p0 = err_pulses;
        for (int i = 0; i < 6; i++) send(1'b1, 1'b1);
        send(1'b1, 1'b0);
        send(1'b0, 1'b1);
        n_cmp++;
        if (stuff_err !== 1'b1 || out_valid !== 1'b0 || err_sticky !== 1'b1) begin
            n_err++;
            $display("FAIL viol_pulse: got err=%b ov=%b sticky=%b, required 1 0 1",
                     stuff_err, out_valid, err_sticky);
        end
        // Second, separate violation after a fresh run.
        for (int i = 0; i < 6; i++) send(1'b1, 1'b1);
        n_cmp++;
        if (stuff_err !== 1'b0 || err_sticky !== 1'b1) begin
            n_err++;
            $display("FAIL viol_one_cycle: got err=%b sticky=%b, required 0 1", stuff_err, err_sticky);
        end
        send(1'b1, 1'b0);
        idle(2);
        check_sb_empty("viol");
        n_cmp++;
        if (err_pulses - p0 != 2) begin
            n_err++;
            $display("FAIL viol_pulses: got %0d, required 2", err_pulses - p0);
        end
        n_cmp++;
        if (drop_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL viol_drop: got %0d, required 0", drop_cnt);
        end
    endtask

    task automatic test_short_run;
        int p0;
        drive(1'b0, 1'b0, 1'b1);
        p0 = err_pulses;
        for (int i = 0; i < 5; i++) send(1'b1, 1'b1);
        send(1'b0, 1'b1);
        // Run counter must be back at 0: six more 1s then a stuffed 0.
        for (int i = 0; i < 6; i++) send(1'b1, 1'b1);
        send(1'b0, 1'b0);
        idle(2);
        check_sb_empty("short");
        n_cmp++;
        if (drop_cnt !== 8'd1 || err_pulses != p0) begin
            n_err++;
            $display("FAIL short_run: got drop=%0d pulses=%0d, required 1 0", drop_cnt, err_pulses - p0);
        end
    endtask

    task automatic test_gap;
        drive(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) send(1'b1, 1'b1);
        idle(1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (out_valid !== 1'b0 || outb !== 1'b1) begin
                n_err++;
                $display("FAIL gap_hold: got ov=%b outb=%b, required 0 1", out_valid, outb);
            end
        end
        for (int i = 0; i < 3; i++) send(1'b1, 1'b1);
        send(1'b0, 1'b0);
        idle(2);
        check_sb_empty("gap");
        n_cmp++;
        if (drop_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL gap_drop: got %0d, required 1", drop_cnt);
        end
    endtask

    task automatic test_clr;
        int p0;
        drive(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 6; i++) send(1'b1, 1'b1);
            send(1'b0, 1'b0);
        end
        for (int i = 0; i < 6; i++) send(1'b1, 1'b1);
        send(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) send(1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        n_cmp++;
        if (drop_cnt !== 8'd5 || err_sticky !== 1'b1) begin
            n_err++;
            $display("FAIL clr_pre: got drop=%0d sticky=%b, required 5 1", drop_cnt, err_sticky);
        end
        drive(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (drop_cnt !== 8'd0 || err_sticky !== 1'b0 || out_valid !== 1'b0 || stuff_err !== 1'b0) begin
            n_err++;
            $display("FAIL clr_post: got drop=%0d sticky=%b ov=%b err=%b, required 0 0 0 0",
                     drop_cnt, err_sticky, out_valid, stuff_err);
        end
        p0 = err_pulses;
        for (int i = 0; i < 6; i++) send(1'b1, 1'b1);
        send(1'b0, 1'b0);
        idle(2);
        check_sb_empty("clr");
        n_cmp++;
        if (drop_cnt !== 8'd1 || err_pulses != p0) begin
            n_err++;
            $display("FAIL clr_run: got drop=%0d pulses=%0d, required 1 0", drop_cnt, err_pulses - p0);
        end
    endtask

    task automatic test_reset_midrun;
        int p0;
        for (int i = 0; i < 4; i++) send(1'b1, 1'b1);
        idle(1);
        #2 rst_L = 1'b0;
        #1;
        n_cmp++;
        if ({outb, out_valid, stuff_err, err_sticky, drop_cnt} !== 12'h0) begin
            n_err++;
            $display("FAIL reset_mid: got %b %b %b %b %h, required all 0",
                     outb, out_valid, stuff_err, err_sticky, drop_cnt);
        end
        #2 rst_L = 1'b1;
        p0 = err_pulses;
        for (int i = 0; i < 6; i++) send(1'b1, 1'b1);
        send(1'b0, 1'b0);
        idle(2);
        check_sb_empty("rstmid");
        n_cmp++;
        if (drop_cnt !== 8'd1 || err_pulses != p0) begin
            n_err++;
            $display("FAIL rstmid_run: got drop=%0d pulses=%0d, required 1 0", drop_cnt, err_pulses - p0);
        end
    endtask

    // Reference stuffer: insert a 0 after every six consecutive source 1s.
    task automatic stuff_src(input bit b, inout int run);
        send(b, 1'b1);
        run = b ? run + 1 : 0;
        if (run == 6) begin
            send(1'b0, 1'b0);
            run = 0;
        end
    endtask

    task automatic test_loopback;
        int run = 0;
        int p0;
        drive(1'b0, 1'b0, 1'b1);
        p0 = err_pulses;
        for (int i = 0; i < 400; i++) stuff_src(($urandom % 8) != 0, run);
        // Reset mid-run: stuffer and destuffer both restart their run count.
        idle(1);
        @(posedge clk);
        #2 rst_L = 1'b0;
        sb.delete();
        run = 0;
        #2 rst_L = 1'b1;
        for (int i = 0; i < 1900; i++) stuff_src(1'b1, run);
        idle(2);
        n_cmp++;
        if (drop_cnt !== 8'd255) begin
            n_err++;
            $display("FAIL loop_sat: got %0d, required 255", drop_cnt);
        end
        for (int i = 0; i < 500; i++) stuff_src(($urandom % 6) != 0, run);
        idle(2);
        check_sb_empty("loop");
        n_cmp++;
        if (drop_cnt !== 8'd255 || err_pulses != p0 || err_sticky !== 1'b0) begin
            n_err++;
            $display("FAIL loop_end: got drop=%0d pulses=%0d sticky=%b, required 255 0 0",
                     drop_cnt, err_pulses - p0, err_sticky);
        end
    endtask

    initial begin
        test_reset();
        test_stuffed();
        test_violation();
        test_short_run();
        test_gap();
        test_clr();
        test_reset_midrun();
        test_loopback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
